// File: rtl/sdf_bf2_stage_if.sv
// Sample stream bundle between pipeline FFT stages: valid, start-of-frame,
// and one complex sample.
interface sdf_bf2_stage_if #(
  parameter int unsigned WIDTH = 16
);
  logic             valid;
  logic             sop;
  logic [WIDTH-1:0] re;
  logic [WIDTH-1:0] im;

  modport master (output valid, sop, re, im);
  modport slave  (input  valid, sop, re, im);
endinterface

// File: rtl/sdf_bf2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: a DELAY-deep feedback
// buffer pairs samples half a frame apart and emits scaled sums, then diffs.
module sdf_bf2_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DELAY = 4,
  parameter int unsigned INDEX = 2
) (
  input  logic             clk,
  input  logic             rst,
  sdf_bf2_stage_if.slave   in_s,
  sdf_bf2_stage_if.master  out_m
);

  localparam int unsigned CW    = INDEX + 1;
  localparam int unsigned FRAME = 2 * DELAY;

  logic [CW-1:0]    cnt_q, cnt_d, cnt_eff;
  logic             primed_q, primed_d;
  logic [INDEX-1:0] ptr_q;
  logic [WIDTH-1:0] fb_re_q [DELAY];
  logic [WIDTH-1:0] fb_im_q [DELAY];
  logic [WIDTH-1:0] head_re, head_im, wr_re, wr_im;
  logic [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
  logic             resync, half1, last;
  logic             out_valid_q, out_sop_q, out_valid_d, out_sop_d;
  logic [WIDTH-1:0] out_re_q, out_im_q, out_re_d, out_im_d;

  // Butterfly datapath, frame sequencing and output selection.
  always_comb begin
    head_re = fb_re_q[ptr_q];
    head_im = fb_im_q[ptr_q];
    cnt_eff = in_s.sop ? '0 : cnt_q;
    resync  = in_s.valid && in_s.sop && (cnt_q != '0);
    half1   = cnt_eff[INDEX];
    last    = (cnt_eff == CW'(FRAME - 1));
    // Widened by one bit so the halving never overflows.
    sum_re  = {head_re[WIDTH-1], head_re} + {in_s.re[WIDTH-1], in_s.re};
    sum_im  = {head_im[WIDTH-1], head_im} + {in_s.im[WIDTH-1], in_s.im};
    dif_re  = {head_re[WIDTH-1], head_re} - {in_s.re[WIDTH-1], in_s.re};
    dif_im  = {head_im[WIDTH-1], head_im} - {in_s.im[WIDTH-1], in_s.im};

    cnt_d       = cnt_q;
    primed_d    = primed_q;
    wr_re       = in_s.re;
    wr_im       = in_s.im;
    out_valid_d = 1'b0;
    out_sop_d   = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;

    if (in_s.valid) begin
      cnt_d = last ? '0 : cnt_eff + CW'(1);
      if (half1) begin
        out_valid_d = 1'b1;
        out_sop_d   = (cnt_eff == CW'(DELAY));
        out_re_d    = sum_re[WIDTH:1];
        out_im_d    = sum_im[WIDTH:1];
        wr_re       = dif_re[WIDTH:1];
        wr_im       = dif_im[WIDTH:1];
        if (last) primed_d = 1'b1;
      end else begin
        primed_d    = primed_q && !resync;
        out_valid_d = primed_d;
        out_re_d    = head_re;
        out_im_d    = head_im;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      for (int unsigned i = 0; i < DELAY; i++) begin
        fb_re_q[i] <= '0;
        fb_im_q[i] <= '0;
      end
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      // Rotating pointer: the head is always the entry written DELAY samples ago.
      if (in_s.valid) begin
        fb_re_q[ptr_q] <= wr_re;
        fb_im_q[ptr_q] <= wr_im;
        ptr_q          <= ptr_q + INDEX'(1);
      end
    end
  end

  assign out_m.valid = out_valid_q;
  assign out_m.sop   = out_sop_q;
  assign out_m.re    = out_re_q;
  assign out_m.im    = out_im_q;

endmodule

// File: tb/tb_sdf_bf2_stage.sv
// Directed and random stimulus for sdf_bf2_stage, checked against a
// frame-position reference model.
module tb_sdf_bf2_stage;

  localparam int unsigned WIDTH = 16;
  localparam int          DELAY = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdf_bf2_stage_if #(.WIDTH(WIDTH)) in_if ();
  sdf_bf2_stage_if #(.WIDTH(WIDTH)) out_if ();

  sdf_bf2_stage #(.WIDTH(WIDTH), .DELAY(DELAY), .INDEX(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .in_s  (in_if),
    .out_m (out_if)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_sop   = 0;

  // Reference model: position within frame, primed flag, first-half samples
  // of the current frame and pending halved diffs of the previous frame.
  int m_pos, m_primed;
  int m_cur_re [DELAY];
  int m_cur_im [DELAY];
  int m_dif_re [DELAY];
  int m_dif_im [DELAY];

  function automatic int half_floor(int v);
    if (v < 0 && (v % 2) != 0) return v / 2 - 1;
    return v / 2;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic model_reset();
    m_pos = 0;
    m_primed = 0;
    for (int i = 0; i < DELAY; i++) begin
      m_cur_re[i] = 0; m_cur_im[i] = 0; m_dif_re[i] = 0; m_dif_im[i] = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input logic v, input logic s, input int re, input int im);
    bit ev, es;
    int er, ei, k;
    in_if.valid = v;
    in_if.sop   = s;
    in_if.re    = 16'(re);
    in_if.im    = 16'(im);
    @(posedge clk);
    #1;
    ev = 0; es = 0; er = 0; ei = 0;
    if (v) begin
      if (s) begin
        if (m_pos != 0) m_primed = 0;
        m_pos = 0;
      end
      if (m_pos < DELAY) begin
        ev = (m_primed != 0);
        er = m_dif_re[m_pos];
        ei = m_dif_im[m_pos];
        m_cur_re[m_pos] = re;
        m_cur_im[m_pos] = im;
      end else begin
        k  = m_pos - DELAY;
        ev = 1;
        es = (m_pos == DELAY);
        er = half_floor(m_cur_re[k] + re);
        ei = half_floor(m_cur_im[k] + im);
        m_dif_re[k] = half_floor(m_cur_re[k] - re);
        m_dif_im[k] = half_floor(m_cur_im[k] - im);
        if (m_pos == 2 * DELAY - 1) m_primed = 1;
      end
      m_pos = (m_pos + 1) % (2 * DELAY);
    end
    chk("out_valid", 16'(out_if.valid), 16'(ev));
    chk("out_sop", 16'(out_if.sop), 16'(es));
    if (ev) begin
      chk("out_re", out_if.re, 16'(er));
      chk("out_im", out_if.im, 16'(ei));
    end
    if (out_if.sop === 1'b1) n_sop++;
  endtask

  task automatic do_reset(input logic v);
    rst = 1'b1;
    in_if.valid = v;
    in_if.sop   = 1'b0;
    in_if.re    = 16'h1234;
    in_if.im    = 16'h5678;
    @(posedge clk);
    #1;
    chk("rst_valid", 16'(out_if.valid), 16'h0);
    chk("rst_sop", 16'(out_if.sop), 16'h0);
    chk("rst_re", out_if.re, 16'h0);
    chk("rst_im", out_if.im, 16'h0);
    rst = 1'b0;
    model_reset();
    n_sop = 0;
  endtask

  task automatic random_samples(input int n, input int start_pos);
    for (int i = 0; i < n; i++)
      cyc(1'b1, ((start_pos + i) % (2 * DELAY)) == 0, rnd16(), rnd16());
  endtask

  int ex_re [8] = '{3, 32767, -32768, 32767, -4, 32767, -32768, -32768};
  int ex_im [8] = '{32767, -32768, 3, 32767, -32768, -32768, -4, 32767};

  initial begin
    rst = 1'b1;
    in_if.valid = 1'b0; in_if.sop = 1'b0; in_if.re = '0; in_if.im = '0;
    model_reset();
    do_reset(1'b0);

    // Basic frame followed by four zero samples draining the diffs.
    for (int i = 0; i < 8; i++) cyc(1'b1, i == 0, 2 * (i + 1), 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, i == 0, 0, 0);

    // Extreme pairs on both paths.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b1, i == 0, ex_re[i], ex_im[i]);
    for (int i = 0; i < 4; i++) cyc(1'b1, i == 0, 0, 0);

    // Basic frame with bubbles; in_sop without in_valid must be ignored.
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, i == 0 || i == 8, (i < 8) ? 2 * (i + 1) : 0, 0);
      cyc(1'b0, 1'b1, 999, -999);
    end

    // Resync: in_sop arriving at cnt=5 of the second frame.
    do_reset(1'b0);
    random_samples(8, 0);
    random_samples(5, 0);
    random_samples(8 + 4, 0);

    // Reset mid-stream at cnt=6 with in_valid high, then a fresh frame.
    do_reset(1'b0);
    random_samples(6, 0);
    do_reset(1'b1);
    random_samples(8 + 4, 0);

    // Continuous streaming of three back-to-back random frames.
    do_reset(1'b0);
    random_samples(3 * 8 + 4, 0);
    chk("sop_count", 16'(n_sop), 16'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
